// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//   Byte-addressed, little-endian data memory for the RV32 MEM stage.
//   Stores (SB/SH/SW) commit on the rising clock edge. Loads (LB/LH/LW/LBU/LHU)
//   are combinational with zero latency. Misaligned halfword/word accesses are
//   flagged and have no effect: a misaligned store writes nothing and a
//   misaligned load returns 0.
//
// Ports
//   clk         in   1   clock; stores commit on the rising edge
//   rst_n       in   1   asynchronous active-low reset; clears the whole array
//   MemRead     in   1   load enable (ReadData is 0 when low)
//   MemWrite    in   1   store enable
//   funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   address     in  32   byte address; wraps modulo 4*DEPTH_WORDS
//   WriteData   in  32   store data; low byte/half/word is used
//   ReadData    out 32   load result, sign/zero-extended per funct3
//   misaligned  out  1   alignment fault, a function of funct3/address only
// -----------------------------------------------------------------------------
module data_memory #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        misaligned
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [31:0]       mem_q [DEPTH_WORDS];
   logic [31:0]       mem_d;
   logic              wr_en;

   logic [ADDR_W-1:0] word_idx;
   logic [1:0]        byte_off;
   logic [31:0]       cur_word;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;

   // Address bits above the array are ignored so accesses wrap.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^address[31:ADDR_W+2];

   assign word_idx = address[ADDR_W+1:2];
   assign byte_off = address[1:0];
   assign cur_word = mem_q[word_idx];
   assign rd_byte  = cur_word[{byte_off, 3'b000} +: 8];
   assign rd_half  = cur_word[{address[1], 4'b0000} +: 16];

   // Alignment check depends only on access size, never on the enables.
   always_comb begin
      misaligned = 1'b0;
      case (funct3)
         F3_H, F3_HU: misaligned = address[0];
         F3_W:        misaligned = (address[1:0] != 2'b00);
         default:     misaligned = 1'b0;
      endcase
   end

   // Store merge: start from the current word and overwrite only the lanes
   // selected by size and offset, so untouched lanes keep their contents.
   always_comb begin
      mem_d = cur_word;
      wr_en = 1'b0;
      if (MemWrite && !misaligned) begin
         case (funct3)
            F3_B: begin
               wr_en = 1'b1;
               mem_d[{byte_off, 3'b000} +: 8] = WriteData[7:0];
            end
            F3_H: begin
               wr_en = 1'b1;
               mem_d[{address[1], 4'b0000} +: 16] = WriteData[15:0];
            end
            F3_W: begin
               wr_en = 1'b1;
               mem_d = WriteData;
            end
            default: wr_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[word_idx] <= mem_d;
      end
   end

   // Load path reads the pre-edge array, so a same-cycle store to the same
   // word becomes visible only after the clock edge.
   always_comb begin
      ReadData = '0;
      if (MemRead && !misaligned) begin
         case (funct3)
            F3_B:    ReadData = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   ReadData = {24'h0, rd_byte};
            F3_H:    ReadData = {{16{rd_half[15]}}, rd_half};
            F3_HU:   ReadData = {16'h0, rd_half};
            F3_W:    ReadData = cur_word;
            default: ReadData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

   localparam int DEPTH_WORDS = 256;
   localparam int W = 32;

   logic        clk;
   logic        rst_n;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  funct3;
   logic [31:0] address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        misaligned;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] exp_q[$];

   // Byte model of a small scratch region used by the random phase.
   localparam logic [31:0] RND_BASE  = 32'h0000_0100;
   localparam int          RND_BYTES = 32;
   logic [7:0] mdl [RND_BYTES];

   data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .funct3     (funct3),
      .address    (address),
      .WriteData  (WriteData),
      .ReadData   (ReadData),
      .misaligned (misaligned)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic sb_push(input logic [W-1:0] exp);
      exp_q.push_back(exp);
   endtask

   task automatic sb_pop_check(input string tag, input logic [W-1:0] got);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: got 0x%08h expected <empty scoreboard>", tag, got);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, got, e);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic idle();
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      funct3    = 3'b000;
      address   = 32'h0;
      WriteData = 32'h0;
   endtask

   task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      funct3    = f3;
      address   = a;
      WriteData = d;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
   endtask

   // Drive a load, record expectations, then compare away from the edge.
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp_data, input logic exp_mis);
      @(negedge clk);
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      funct3   = f3;
      address  = a;
      sb_push(exp_data);
      sb_push({31'h0, exp_mis});
      #1;
      sb_pop_check({tag, "_data"}, ReadData);
      sb_pop_check({tag, "_mis"}, {31'h0, misaligned});
      MemRead = 1'b0;
   endtask

   // ---------------- random phase helpers ----------------
   function automatic logic [31:0] mdl_word(input int off);
      return {mdl[off+3], mdl[off+2], mdl[off+1], mdl[off]};
   endfunction

   task automatic random_phase(input int iters);
      int op, off;
      logic [31:0] d, e;
      for (int k = 0; k < iters; k++) begin
         op  = $urandom_range(0, 5);
         off = $urandom_range(0, RND_BYTES - 1);
         d   = $urandom();
         case (op)
            0: begin
               do_store(3'b000, RND_BASE + off, d);
               mdl[off] = d[7:0];
            end
            1: begin
               off = off & ~1;
               do_store(3'b001, RND_BASE + off, d);
               mdl[off]   = d[7:0];
               mdl[off+1] = d[15:8];
            end
            2: begin
               off = off & ~3;
               do_store(3'b010, RND_BASE + off, d);
               mdl[off]   = d[7:0];
               mdl[off+1] = d[15:8];
               mdl[off+2] = d[23:16];
               mdl[off+3] = d[31:24];
            end
            3: begin
               if (d[0]) begin
                  e = {{24{mdl[off][7]}}, mdl[off]};
                  do_load("rnd_lb", 3'b000, RND_BASE + off, e, 1'b0);
               end else begin
                  e = {24'h0, mdl[off]};
                  do_load("rnd_lbu", 3'b100, RND_BASE + off, e, 1'b0);
               end
            end
            4: begin
               off = off & ~1;
               if (d[0]) begin
                  e = {{16{mdl[off+1][7]}}, mdl[off+1], mdl[off]};
                  do_load("rnd_lh", 3'b001, RND_BASE + off, e, 1'b0);
               end else begin
                  e = {16'h0, mdl[off+1], mdl[off]};
                  do_load("rnd_lhu", 3'b101, RND_BASE + off, e, 1'b0);
               end
            end
            default: begin
               off = off & ~3;
               do_load("rnd_lw", 3'b010, RND_BASE + off, mdl_word(off), 1'b0);
            end
         endcase
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      idle();
      for (int i = 0; i < RND_BYTES; i++) mdl[i] = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset state
      do_load("rst_lw10", 3'b010, 32'h10, 32'h0, 1'b0);

      // Word store / byte and half loads
      do_store(3'b010, 32'h10, 32'hAABBCCDD);
      do_load("lw10",   3'b010, 32'h10, 32'hAABBCCDD, 1'b0);
      do_load("lb10",   3'b000, 32'h10, 32'hFFFFFFDD, 1'b0);
      do_load("lbu10",  3'b100, 32'h10, 32'h000000DD, 1'b0);
      do_load("lb12",   3'b000, 32'h12, 32'hFFFFFFBB, 1'b0);
      do_load("lbu13",  3'b100, 32'h13, 32'h000000AA, 1'b0);
      do_load("lh12",   3'b001, 32'h12, 32'hFFFFAABB, 1'b0);
      do_load("lhu10",  3'b101, 32'h10, 32'h0000CCDD, 1'b0);

      // Half store, then byte store merges into the upper half
      do_store(3'b001, 32'h20, 32'h0000BEEF);
      do_load("lh20",   3'b001, 32'h20, 32'hFFFFBEEF, 1'b0);
      do_load("lhu20",  3'b101, 32'h20, 32'h0000BEEF, 1'b0);
      do_store(3'b000, 32'h22, 32'h00000012);
      do_load("lw20",   3'b010, 32'h20, 32'h0012BEEF, 1'b0);

      // Misaligned store: flag visible with and without MemWrite, no effect
      @(negedge clk);
      MemWrite = 1'b1; funct3 = 3'b010; address = 32'h13; WriteData = 32'hDEADBEEF;
      #1;
      sb_push(32'h1);
      sb_pop_check("sw13_mis_we", {31'h0, misaligned});
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      #1;
      sb_push(32'h1);
      sb_pop_check("sw13_mis_held", {31'h0, misaligned});
      do_load("lw10_after_mis", 3'b010, 32'h10, 32'hAABBCCDD, 1'b0);
      do_load("lh21_mis",       3'b001, 32'h21, 32'h0,        1'b1);
      do_load("lw12_mis",       3'b010, 32'h12, 32'h0,        1'b1);
      do_load("lb11_aligned",   3'b000, 32'h11, 32'hFFFFFFCC, 1'b0);

      // Misaligned halfword store writes nothing
      do_store(3'b001, 32'h21, 32'h00005555);
      do_load("lw20_after_sh_mis", 3'b010, 32'h20, 32'h0012BEEF, 1'b0);

      // Unsupported store encoding writes nothing
      do_store(3'b011, 32'h10, 32'h01234567);
      do_load("lw10_after_f3_011", 3'b010, 32'h10, 32'hAABBCCDD, 1'b0);
      do_load("ld_f3_110",         3'b110, 32'h10, 32'h0,        1'b0);

      // Read and write same word in one cycle
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b1; funct3 = 3'b010; address = 32'h10; WriteData = 32'h55667788;
      #1;
      sb_push(32'hAABBCCDD);
      sb_pop_check("rw_pre_edge", ReadData);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      sb_push(32'h55667788);
      sb_pop_check("rw_post_edge", ReadData);
      MemRead = 1'b0;

      // MemRead low forces zero
      @(negedge clk);
      funct3 = 3'b010; address = 32'h10;
      #1;
      sb_push(32'h0);
      sb_pop_check("memread_low", ReadData);

      // Address wrap
      do_store(3'b010, 32'(4 * DEPTH_WORDS + 4), 32'h11223344);
      do_load("lw4_wrap", 3'b010, 32'h4, 32'h11223344, 1'b0);

      // Reset mid-cycle, store attempted during reset
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      MemRead = 1'b1; funct3 = 3'b010; address = 32'h10;
      #1;
      sb_push(32'h0);
      sb_pop_check("lw10_in_reset", ReadData);
      MemRead = 1'b0;
      MemWrite = 1'b1; funct3 = 3'b010; address = 32'h30; WriteData = 32'hCAFEF00D;
      repeat (2) @(posedge clk);
      #1;
      MemWrite = 1'b0;
      rst_n = 1'b1;
      do_load("lw10_after_rst", 3'b010, 32'h10, 32'h0, 1'b0);
      do_load("lw30_after_rst", 3'b010, 32'h30, 32'h0, 1'b0);
      do_load("lw4_after_rst",  3'b010, 32'h4,  32'h0, 1'b0);

      // Random traffic against the byte model
      random_phase(60);

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed, little-endian data memory for the RV32 core's MEM stage.
- Serves RV32I loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW), selected by funct3.
- Stores are synchronous; loads are combinational.
- Flags misaligned halfword/word accesses and suppresses their effect.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (1 KiB default); must be a power of two.
- ADDR_W, log2(DEPTH_WORDS), word-index width derived from DEPTH_WORDS.

Ports:
- clk  in  1  clock; stores commit on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load enable.
- MemWrite  in  1  store enable.
- funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for stores 000 SB, 001 SH, 010 SW.
- address  in  32  byte address.
- WriteData  in  32  store data; the low byte/half/word is used.
- ReadData  out  32  load result, extended per funct3.
- misaligned  out  1  alignment fault flag.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n).
- While rst_n=0, every memory word is cleared to 0 and stores are ignored.
- Outputs are combinational, so after reset ReadData reads 0.
- Storage is an array of DEPTH_WORDS 32-bit words.
- Word index = address[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte offset = address[1:0]. Little-endian: byte 0 = bits 7:0.
- misaligned is combinational, a pure function of funct3 and address, and independent of MemRead/MemWrite:
  - funct3 001/101 (half): misaligned = address[0].
  - funct3 010 (word): misaligned = (address[1:0] != 0).
  - Byte and unsupported encodings: misaligned = 0.
- Store, on rising clk when rst_n=1, MemWrite=1 and misaligned=0:
  - SB writes WriteData[7:0] to the selected byte lane.
  - SH writes WriteData[15:0] to lanes {1,0} or {3,2} per address[1].
  - SW writes all four lanes.
  - Other lanes are unchanged.
  - Unsupported funct3 (011, 110, 111) writes nothing.
  - A misaligned store writes nothing.
- Load, combinational, zero latency:
  - If MemRead=0, ReadData=0.
  - LB: sign-extend the selected byte. LBU: zero-extend it.
  - LH/LHU: sign-/zero-extend the selected half.
  - LW: full word.
  - Misaligned or unsupported funct3: ReadData=0.
- Read and write in the same cycle to the same word: ReadData shows the pre-edge contents and reflects the new data after the edge.
- MemRead and MemWrite may both be 1; both actions occur.
- Reset asserted mid-cycle clears the array immediately; a store pending in that cycle is lost.

Test Plan:
- SW 0xAABBCCDD @0x10, then LW @0x10 -> ReadData=0xAABBCCDD, misaligned=0.
- LB @0x10 -> 0xFFFFFFDD; LBU @0x10 -> 0x000000DD; LB @0x12 -> 0xFFFFFFBB; LBU @0x13 -> 0x000000AA.
- SH 0x0000BEEF @0x20, then LH @0x20 -> 0xFFFFBEEF and LHU @0x20 -> 0x0000BEEF. Then SB 0x12 @0x22 and LW @0x20 -> 0x0012BEEF.
- SW 0xDEADBEEF @0x13 -> misaligned=1 (remains 1 after MemWrite drops while funct3/address are held); LW @0x10 still 0xAABBCCDD. LH @0x21 -> misaligned=1, ReadData=0.
- Drop rst_n mid-run, release, then LW @0x10 -> 0x00000000. A store issued during reset leaves memory at 0.
- Address wrap: SW 0x11223344 @(4*DEPTH_WORDS+0x4), then LW @0x4 -> 0x11223344. Any load with MemRead=0 -> ReadData=0.
